// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared synth voice types: envelope states and sample-width helpers
package synth_pkg;

    localparam int WAVE_DEPTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    function automatic int wave_mid(input int depth);
        return 1 << (depth - 1);
    endfunction

    function automatic int wave_max(input int depth);
        return (1 << depth) - 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running prescaler producing a one-clock Tick every PRESCALE clocks
module tick_divider #(
    parameter int PRESCALE = 256
) (
    input  logic Clock,
    input  logic Reset,
    output logic Tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign Tick = (count == LAST);

endmodule

// File: rtl/envelope_shaper.sv
// rtl/envelope_shaper.sv - ADSR envelope generator scaling the voice sample around mid-scale
module envelope_shaper
    import synth_pkg::*;
#(
    parameter int WAVE_DEPTH = WAVE_DEPTH_DEFAULT,
    parameter int PRESCALE   = 256
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Gate,
    input  logic [WAVE_DEPTH-1:0] AttackRate,
    input  logic [WAVE_DEPTH-1:0] DecayRate,
    input  logic [WAVE_DEPTH-1:0] SustainLevel,
    input  logic [WAVE_DEPTH-1:0] ReleaseRate,
    input  logic [WAVE_DEPTH-1:0] Waveform,
    output logic [WAVE_DEPTH-1:0] ScaledWave,
    output logic [WAVE_DEPTH-1:0] Envelope,
    output logic                  Active
);

    localparam int W = WAVE_DEPTH;
    localparam logic [W-1:0] MID_W = W'(wave_mid(W));
    localparam logic [W-1:0] MAX_W = W'(wave_max(W));

    function automatic logic [W-1:0] rate_or_max(input logic [W-1:0] r);
        return (r == '0) ? MAX_W : r;
    endfunction

    logic       tick;
    env_state_t state;
    logic       gate_q;
    logic       rise;
    logic       fall;

    tick_divider #(.PRESCALE(PRESCALE)) u_tick (
        .Clock (Clock),
        .Reset (Reset),
        .Tick  (tick)
    );

    assign rise = Gate & ~gate_q;
    assign fall = ~Gate & gate_q;

    logic [W-1:0] atk_r;
    logic [W-1:0] dec_r;
    logic [W-1:0] rel_r;
    logic [W:0]   atk_sum;
    logic [W:0]   dec_floor;

    assign atk_r     = rate_or_max(AttackRate);
    assign dec_r     = rate_or_max(DecayRate);
    assign rel_r     = rate_or_max(ReleaseRate);
    // One extra bit so the step never wraps past full scale or below sustain
    assign atk_sum   = {1'b0, Envelope} + {1'b0, atk_r};
    assign dec_floor = {1'b0, SustainLevel} + {1'b0, dec_r};

    // gate_q resets high so a Gate held through reset is not seen as a fresh note
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= ENV_IDLE;
            Envelope <= '0;
            Active   <= 1'b0;
            gate_q   <= 1'b1;
        end else begin
            gate_q <= Gate;
            if (rise) begin
                state  <= ENV_ATTACK;
                Active <= 1'b1;
            end else if (fall && (state == ENV_ATTACK || state == ENV_DECAY ||
                                  state == ENV_SUSTAIN)) begin
                state  <= ENV_RELEASE;
                Active <= 1'b1;
            end else begin
                case (state)
                    ENV_IDLE: begin
                        Envelope <= '0;
                    end
                    ENV_ATTACK: begin
                        if (tick) begin
                            if (atk_sum >= {1'b0, MAX_W}) begin
                                Envelope <= MAX_W;
                                state    <= ENV_DECAY;
                            end else begin
                                Envelope <= atk_sum[W-1:0];
                            end
                        end
                    end
                    ENV_DECAY: begin
                        if (tick) begin
                            if ({1'b0, Envelope} <= dec_floor) begin
                                Envelope <= SustainLevel;
                                state    <= ENV_SUSTAIN;
                            end else begin
                                Envelope <= Envelope - dec_r;
                            end
                        end
                    end
                    ENV_SUSTAIN: begin
                        Envelope <= SustainLevel;
                    end
                    ENV_RELEASE: begin
                        if (tick) begin
                            if (Envelope <= rel_r) begin
                                Envelope <= '0;
                                state    <= ENV_IDLE;
                                Active   <= 1'b0;
                            end else begin
                                Envelope <= Envelope - rel_r;
                            end
                        end
                    end
                    default: begin
                        Envelope <= '0;
                        state    <= ENV_IDLE;
                        Active   <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic signed [W:0]     diff;
    logic signed [2*W+1:0] prod;

    assign diff = $signed({1'b0, Waveform}) - $signed({1'b0, MID_W});
    assign prod = (2*W+2)'(diff) * (2*W+2)'($signed({1'b0, Envelope}));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ScaledWave <= MID_W;
        end else begin
            ScaledWave <= MID_W + W'(prod >>> W);
        end
    end

endmodule

// File: tb/tb_envelope_shaper.sv
// tb/tb_envelope_shaper.sv - self-checking bench for envelope_shaper
module tb_envelope_shaper;

    localparam int W = 8;
    localparam int P = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Gate;
    logic [W-1:0] AttackRate, DecayRate, SustainLevel, ReleaseRate, Waveform;
    logic [W-1:0] ScaledWave, Envelope;
    logic         Active;

    always #5 Clock = ~Clock;

    envelope_shaper #(.WAVE_DEPTH(W), .PRESCALE(P)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Gate         (Gate),
        .AttackRate   (AttackRate),
        .DecayRate    (DecayRate),
        .SustainLevel (SustainLevel),
        .ReleaseRate  (ReleaseRate),
        .Waveform     (Waveform),
        .ScaledWave   (ScaledWave),
        .Envelope     (Envelope),
        .Active       (Active)
    );

    typedef enum {M_IDLE, M_ATK, M_DEC, M_SUS, M_REL} mphase_t;

    typedef struct {
        int wave;
        int env;
        int exp_scaled;
    } vec_t;

    mphase_t m_phase;
    int      m_env, m_scaled, m_n;
    bit      m_gq, m_active;
    int      n_checks = 0;
    int      n_fail = 0;
    int      got[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int eff(input int r);
        return (r == 0) ? 255 : r;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE; m_env = 0; m_scaled = 128; m_n = 0; m_gq = 1; m_active = 0;
    endtask

    task automatic model_edge();
        bit tick, rise, fall;
        int a, d, r, s;
        tick = ((m_n % P) == P - 1);
        m_n++;
        rise = Gate && !m_gq;
        fall = !Gate && m_gq;
        a = eff(AttackRate); d = eff(DecayRate); r = eff(ReleaseRate); s = SustainLevel;
        m_scaled = 128 + floor_div((int'(Waveform) - 128) * m_env, 256);
        if (rise) m_phase = M_ATK;
        else if (fall && (m_phase == M_ATK || m_phase == M_DEC || m_phase == M_SUS)) m_phase = M_REL;
        else begin
            case (m_phase)
                M_IDLE: m_env = 0;
                M_ATK: if (tick) begin
                    if (m_env + a >= 255) begin m_env = 255; m_phase = M_DEC; end
                    else m_env = m_env + a;
                end
                M_DEC: if (tick) begin
                    if (m_env <= s + d) begin m_env = s; m_phase = M_SUS; end
                    else m_env = m_env - d;
                end
                M_SUS: m_env = s;
                M_REL: if (tick) begin
                    if (m_env <= r) begin m_env = 0; m_phase = M_IDLE; end
                    else m_env = m_env - r;
                end
                default: m_env = 0;
            endcase
        end
        m_gq = Gate;
        m_active = (m_phase != M_IDLE);
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
        check("model_env", Envelope, m_env);
        check("model_scaled", ScaledWave, m_scaled);
        check("model_active", Active, m_active);
    endtask

    task automatic async_reset();
        #2 Reset = 1'b1;
        #1;
        check("rst_env", Envelope, 0);
        check("rst_scaled", ScaledWave, 128);
        check("rst_active", Active, 0);
        model_reset();
        @(posedge Clock);
        #3 Reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_env(input int target, input int budget);
        for (int i = 0; i < budget && Envelope != target; i++) step();
        check("wait_env", Envelope, target);
    endtask

    task automatic collect(input int cnt, input int budget, input bit chk_peak);
        int  last, prev;
        bit  done;
        got.delete();
        last = Envelope; prev = Envelope; done = 0;
        for (int i = 0; i < budget && got.size() < cnt; i++) begin
            step();
            if (chk_peak && !done && prev == 255) begin
                check("t2_peak_scaled", ScaledWave, 254);
                done = 1;
            end
            prev = Envelope;
            if (Envelope != last) begin got.push_back(Envelope); last = Envelope; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   exp2[9];
        int   exp4[4];
        int   exp5[2];

        vecs = '{'{0, 128, 64}, '{255, 128, 191}, '{255, 255, 254}, '{0, 255, 0},
                 '{128, 255, 128}, '{200, 0, 128}, '{100, 50, 122}, '{255, 100, 177},
                 '{1, 200, 28}, '{127, 1, 127}};
        exp2 = '{64, 128, 192, 255, 223, 191, 159, 127, 100};
        exp4 = '{70, 40, 10, 0};
        exp5 = '{255, 223};

        Reset = 1'b1; Gate = 1'b0;
        AttackRate = 8'd60; DecayRate = 8'd1; SustainLevel = 8'd100; ReleaseRate = 8'd30;
        Waveform = 8'd200;
        #1;
        check("init_env", Envelope, 0);
        check("init_scaled", ScaledWave, 128);
        check("init_active", Active, 0);
        repeat (2) @(posedge Clock);
        #3 Reset = 1'b0;
        model_reset();

        // reset while attacking, Gate held high afterwards
        step(); step();
        Gate = 1'b1;
        wait_env(60, 20);
        check("t1_active_before", Active, 1);
        async_reset();
        repeat (12) step();
        check("t1_idle_active", Active, 0);
        check("t1_idle_env", Envelope, 0);

        // full attack/decay into sustain
        Gate = 1'b0; step();
        AttackRate = 8'd64; DecayRate = 8'd32; SustainLevel = 8'd100; Waveform = 8'd255;
        Gate = 1'b1;
        collect(9, 80, 1);
        for (int i = 0; i < 9; i++)
            check($sformatf("t2_env%0d", i), (i < got.size()) ? got[i] : -1, exp2[i]);
        check("t2_active", Active, 1);

        step(); step();
        SustainLevel = 8'd40;
        step();
        check("t3_sus_track", Envelope, 40);

        for (int i = 0; i < 10; i++) begin
            SustainLevel = 8'(vecs[i].env);
            Waveform = 8'(vecs[i].wave);
            step();
            check($sformatf("tbl_env%0d", i), Envelope, vecs[i].env);
            step();
            check($sformatf("tbl_scaled%0d", i), ScaledWave, vecs[i].exp_scaled);
        end

        // release from 100
        SustainLevel = 8'd100; step();
        ReleaseRate = 8'd30; Gate = 1'b0;
        collect(4, 40, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_env%0d", i), (i < got.size()) ? got[i] : -1, exp4[i]);
        check("t4_active_drop", Active, 0);

        // re-rise during release with full-scale attack step
        AttackRate = 8'd64; Gate = 1'b1;
        wait_env(100, 80);
        Gate = 1'b0;
        wait_env(40, 40);
        AttackRate = 8'd0; DecayRate = 8'd32; Gate = 1'b1;
        step();
        check("t5_active", Active, 1);
        check("t5_env_kept", Envelope, 40);
        collect(2, 20, 0);
        for (int i = 0; i < 2; i++)
            check($sformatf("t5_env%0d", i), (i < got.size()) ? got[i] : -1, exp5[i]);

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) Gate = ~Gate;
            if ($urandom_range(0, 15) == 0) AttackRate = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 90));
            if ($urandom_range(0, 15) == 0) DecayRate = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 90));
            if ($urandom_range(0, 15) == 0) ReleaseRate = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 90));
            if ($urandom_range(0, 15) == 0) SustainLevel = 8'($urandom_range(0, 255));
            Waveform = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/envelope_shaper.md
# envelope_shaper

Per-voice ADSR amplitude stage sitting directly downstream of the waveform generator/mixer. Takes the mixed unsigned `Waveform` sample each clock and scales it, around mid-scale, by an internally generated attack/decay/sustain/release envelope. The envelope is driven by a note `Gate`. The output feeds the audio DAC/PWM stage.

## Interface
Parameters:
- `WAVE_DEPTH`, default 8: sample and envelope width.
- `PRESCALE`, default 256: clocks per envelope step (tick period); must be ≥ 2.

Ports:
- `Clock`  in  1  system clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Gate`  in  1  note on (1) / off (0); sampled synchronously.
- `AttackRate`  in  WAVE_DEPTH  envelope increment per tick in ATTACK; 0 = full-scale step.
- `DecayRate`  in  WAVE_DEPTH  decrement per tick in DECAY; 0 = full-scale step.
- `SustainLevel`  in  WAVE_DEPTH  hold level in SUSTAIN.
- `ReleaseRate`  in  WAVE_DEPTH  decrement per tick in RELEASE; 0 = full-scale step.
- `Waveform`  in  WAVE_DEPTH  unsigned input sample; mid-scale MID = 1<<(WAVE_DEPTH-1).
- `ScaledWave`  out  WAVE_DEPTH  registered, envelope-scaled sample.
- `Envelope`  out  WAVE_DEPTH  current envelope level (registered).
- `Active`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Gate edge detection uses a registered copy `gate_q`:
  - Rise = `Gate & ~gate_q`.
  - Fall = `~Gate & gate_q`.
- Tick prescaler:
  - Free-running counter runs 0..PRESCALE-1 and wraps.
  - `tick` is high when the counter is at PRESCALE-1.
  - Counter is not restarted by Gate.
- Transitions. Edges take priority over tick; both are evaluated in the same cycle.
  - Rise, any state → ATTACK. Envelope is kept (no reset to 0).
  - Fall in ATTACK/DECAY/SUSTAIN → RELEASE. Envelope is kept.
  - ATTACK on tick: if env + rate ≥ WAVE_MAX, env = WAVE_MAX and go to DECAY; else env += rate.
  - DECAY on tick: if env ≤ SustainLevel + rate, env = SustainLevel and go to SUSTAIN; else env −= rate.
  - SUSTAIN: env follows `SustainLevel` every clock (not gated by tick).
  - RELEASE on tick: if env ≤ rate, env = 0 and go to IDLE; else env −= rate.
  - IDLE: env held at 0.
- Arithmetic:
  - Compares and sums use WAVE_DEPTH+1 bits, so there is no wrap.
  - A rate of 0 is substituted by WAVE_MAX before use.
- Scaling:
  - diff = signed(Waveform − MID), WAVE_DEPTH+1 bits.
  - prod = diff × Envelope, signed 2·WAVE_DEPTH+1 bits.
  - ScaledWave = MID + (prod >>> WAVE_DEPTH), arithmetic shift (floor).
  - Envelope 0 gives MID. Envelope WAVE_MAX gives near unity: 255→254, 0→0, 128→128.
- Reset mid-operation: forces IDLE immediately (asynchronously), regardless of Gate. A Gate held high through reset release does not start ATTACK until a fresh rise. `gate_q` resets to 1 to block a false rise.

## Timing
- Reset values:
  - State IDLE.
  - `Envelope` = 0.
  - `ScaledWave` = MID.
  - `Active` = 0.
  - Prescaler counter = 0.
  - `gate_q` = 1.
- Gate edge: the state changes on the first clock edge at which the new `Gate` value is sampled. `Active` is high after that same edge.
- Envelope steps only on tick edges, except that SUSTAIN tracking and edge-triggered state changes are per clock.
- `ScaledWave` latency: 1 clock from `Waveform`/`Envelope` register values to output.
- Single-cycle Gate pulse: the rise edge enters ATTACK; the next edge enters RELEASE.

## Structure
- Shared package `synth_pkg`:
  - Envelope state enum/encoding (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4).
  - WAVE_DEPTH default and MID/WAVE_MAX derivations.
- Sub-module `tick_divider` (parameter PRESCALE; ports `Clock`, `Reset`, `Tick`), reusable by other modulation stages.
- FSM, envelope datapath and scaler live in `envelope_shaper`.

## Test plan
All scenarios use PRESCALE=4, WAVE_DEPTH=8.
1. Reset asserted mid-ATTACK with env=60 → same cycle: Envelope=0, ScaledWave=128, Active=0; Gate held high after release → stays IDLE.
2. Gate rise; Attack=64, Decay=32, Sustain=100; Waveform=255 → Envelope 64,128,192,255 on successive ticks, then 223,191,159,127, then 100 (SUSTAIN); ScaledWave at env=255 is 254.
3. In SUSTAIN, SustainLevel changes 100→40 → Envelope=40 after the next clock, with no tick wait.
4. Gate fall at env=100, Release=30 → 70,40,10,0 on ticks; IDLE after the tick that reaches 0; Active drops.
5. Gate re-rise in RELEASE at env=40, Attack=0 → ATTACK, then next tick env=255, DECAY.
6. Envelope=128, Waveform=0 → ScaledWave=64; Waveform=255 → ScaledWave=191; each 1 clock after the input.
